// File: rtl/fpu_int_to_float.sv
// Multi-cycle integer to IEEE-754 float converter: one operand in flight,
// bit-serial normalization, round-to-nearest-even, valid/ready on both sides.
module fpu_int_to_float #(
   parameter int bitness = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [bitness-1:0] operand,
   input  logic               signed_mode,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [bitness-1:0] result,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int E    = (bitness == 16) ? 5  : (bitness == 32) ? 8  : 11;
   localparam int M    = (bitness == 16) ? 11 : (bitness == 32) ? 24 : 53;
   localparam int BIAS = (1 << (E - 1)) - 1;
   localparam logic [E-1:0] EXP_TOP = E'(BIAS + bitness - 1);

   typedef enum logic [2:0] {IDLE, ABS, NORMALIZE, ROUND, DONE} state_t;

   state_t             state;
   logic [bitness-1:0] op_q;
   logic               sm_q;
   logic               sign;
   logic [bitness-1:0] mag;
   logic [E-1:0]       exp_q;

   logic               in_sign;
   logic [bitness-1:0] mag_abs;
   logic [M-1:0]       mant;
   logic               guard, sticky, rnd_up, carry;
   logic [M-2:0]       frac;
   logic [E-1:0]       exp_rnd;

   always_comb begin
      in_sign = sm_q & op_q[bitness-1];
      mag_abs = in_sign ? (~op_q + bitness'(1)) : op_q;
      mant    = mag[bitness-1 -: M];
      guard   = mag[bitness-M-1];
      sticky  = |(mag << (M + 1));
      rnd_up  = guard & (sticky | mant[0]);
      // an all-ones mantissa wraps the fraction to zero and bumps the exponent
      carry   = rnd_up & (&mant);
      frac    = mant[M-2:0] + (M-1)'(rnd_up);
      exp_rnd = exp_q + E'(carry);
   end

   assign in_ready = (state == IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= '0;
         sm_q      <= 1'b0;
         sign      <= 1'b0;
         mag       <= '0;
         exp_q     <= '0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= operand;
                  sm_q  <= signed_mode;
                  state <= ABS;
               end
            end
            ABS: begin
               sign <= in_sign;
               mag  <= mag_abs;
               // zero still takes the ROUND pass, which packs +0.0 from a
               // cleared exponent and magnitude
               if (mag_abs == '0) begin
                  exp_q <= '0;
                  state <= ROUND;
               end else begin
                  exp_q <= EXP_TOP;
                  state <= NORMALIZE;
               end
            end
            NORMALIZE: begin
               if (mag[bitness-1]) begin
                  state <= ROUND;
               end else begin
                  mag   <= mag << 1;
                  exp_q <= exp_q - E'(1);
               end
            end
            ROUND: begin
               result    <= {sign, exp_rnd, frac};
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_int_to_float.sv
// Randomized + directed bench for fpu_int_to_float (bitness 32) against an
// arithmetic reference model with a per-cycle output compare.
module tb_fpu_int_to_float;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] operand = '0;
   logic        signed_mode = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] result;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   fpu_int_to_float #(.bitness(32)) dut (
      .clock(clock), .reset(reset), .operand(operand), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready), .result(result),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   // Exact magnitude of the integer as a plain number.
   function automatic longint ref_mag(input logic [31:0] op, input logic sm);
      if (sm && op[31]) return (longint'(1) << 32) - longint'(op);
      return longint'(op);
   endfunction

   function automatic int ref_log2(input longint v);
      int k = 0;
      while ((v >> (k + 1)) != 0) k++;
      return k;
   endfunction

   // Value-level rounding: keep 24 significant bits, ties to even.
   function automatic logic [31:0] ref_conv(input logic [31:0] op, input logic sm);
      longint v, q, r, half;
      int k, sh;
      logic s;
      s = sm && op[31];
      v = ref_mag(op, sm);
      if (v == 0) return 32'h0;
      k = ref_log2(v);
      if (k <= 23) begin
         q = v << (23 - k);
      end else begin
         sh   = k - 23;
         q    = v >> sh;
         r    = v - (q << sh);
         half = longint'(1) << (sh - 1);
         if (r > half || (r == half && q[0])) q++;
         if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            k++;
         end
      end
      return {s, 8'(127 + k), 23'(q)};
   endfunction

   function automatic int ref_lat(input logic [31:0] op, input logic sm);
      longint v;
      v = ref_mag(op, sm);
      if (v == 0) return 2;
      return 3 + (31 - ref_log2(v));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle model: countdown from acceptance to result, then hold until taken.
   logic        m_busy = 1'b0;
   logic        m_valid = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_result = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0;
         m_valid = 1'b0;
         m_cnt = 0;
      end else if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_valid = 1'b1;
            m_result = m_pend;
         end
      end else if (m_valid) begin
         if (out_ready) m_valid = 1'b0;
      end else if (in_valid) begin
         m_busy = 1'b1;
         m_cnt = ref_lat(operand, signed_mode);
         m_pend = ref_conv(operand, signed_mode);
      end
   end

   always @(negedge clock) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready", 64'(in_ready), 64'(!m_busy && !m_valid));
      if (m_valid) chk("result", 64'(result), 64'(m_result));
   end

   task automatic do_conv(input logic [31:0] op, input logic sm, input int hold,
                          input bit junk, output logic [31:0] res, output int lat);
      @(negedge clock);
      operand = op;
      signed_mode = sm;
      in_valid = 1'b1;
      @(posedge clock);
      lat = 0;
      @(negedge clock);
      in_valid = 1'b0;
      while (!out_valid && lat < 200) begin
         if (junk) begin
            in_valid = 1'($urandom);
            operand = $urandom;
            signed_mode = 1'($urandom);
         end
         lat++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      if (lat >= 200) chk("timeout", 64'(out_valid), 64'(1));
      res = result;
      repeat (hold) begin
         if (junk) begin
            in_valid = 1'b1;
            operand = $urandom;
         end
         @(negedge clock);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res, op;
      logic        sm;
      int          lat;

      // model pinned to hand-computed values
      chk("ref_one",    64'(ref_conv(32'd1, 1'b1)),         64'h3F800000);
      chk("ref_m1",     64'(ref_conv(32'hFFFFFFFF, 1'b1)),  64'hBF800000);
      chk("ref_min",    64'(ref_conv(32'h80000000, 1'b1)),  64'hCF000000);
      chk("ref_tie_e",  64'(ref_conv(32'd16777217, 1'b0)),  64'h4B800000);
      chk("ref_tie_u",  64'(ref_conv(32'd16777219, 1'b0)),  64'h4B800002);
      chk("ref_carry",  64'(ref_conv(32'hFFFFFFFF, 1'b0)),  64'h4F800000);
      chk("ref_three",  64'(ref_conv(32'd3, 1'b1)),         64'h40400000);
      chk("ref_lat1",   64'(ref_lat(32'd1, 1'b1)),          64'd34);

      #1;
      chk("rst_result", 64'(result), 64'h0);
      chk("rst_valid",  64'(out_valid), 64'h0);
      chk("rst_ready",  64'(in_ready), 64'h1);
      #21 reset = 1'b1;

      do_conv(32'd1, 1'b1, 0, 1'b0, res, lat);
      chk("one_res", 64'(res), 64'h3F800000);
      chk("one_lat", 64'(lat), 64'd34);
      do_conv(32'hFFFFFFFF, 1'b1, 1, 1'b0, res, lat);
      chk("m1_res", 64'(res), 64'hBF800000);
      do_conv(32'h80000000, 1'b1, 0, 1'b0, res, lat);
      chk("min_res", 64'(res), 64'hCF000000);
      chk("min_lat", 64'(lat), 64'd3);
      do_conv(32'd0, 1'b1, 0, 1'b0, res, lat);
      chk("zero_res", 64'(res), 64'h0);
      chk("zero_lat", 64'(lat), 64'd2);
      do_conv(32'd16777217, 1'b0, 0, 1'b0, res, lat);
      chk("tie_even", 64'(res), 64'h4B800000);
      do_conv(32'd16777219, 1'b1, 0, 1'b0, res, lat);
      chk("tie_up", 64'(res), 64'h4B800002);
      do_conv(32'hFFFFFFFF, 1'b0, 0, 1'b0, res, lat);
      chk("carry", 64'(res), 64'h4F800000);
      // backpressure with junk input offered while DONE
      do_conv(32'd1000, 1'b0, 5, 1'b1, res, lat);
      chk("bp_res", 64'(res), 64'h447A0000);

      // abort operand 1 mid-normalize
      @(negedge clock);
      operand = 32'd1;
      signed_mode = 1'b1;
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      #1;
      chk("abort_result", 64'(result), 64'h0);
      chk("abort_valid",  64'(out_valid), 64'h0);
      chk("abort_ready",  64'(in_ready), 64'h1);
      @(negedge clock);
      #2 reset = 1'b1;
      do_conv(32'd3, 1'b1, 0, 1'b0, res, lat);
      chk("post_rst_res", 64'(res), 64'h40400000);
      chk("post_rst_lat", 64'(lat), 64'd33);

      for (int i = 0; i < 60; i++) begin
         op = $urandom;
         case ($urandom % 4)
            0: op = op >> ($urandom % 32);
            1: op = $urandom % 8;
            2: op = 32'h80000000 ^ ($urandom % 4);
            default: ;
         endcase
         sm = 1'($urandom);
         do_conv(op, sm, int'($urandom % 3), 1'b1, res, lat);
         chk("rand_res", 64'(res), 64'(ref_conv(op, sm)));
         chk("rand_lat", 64'(lat), 64'(ref_lat(op, sm)));
      end

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
